// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package cpu_ctrl_pkg;

    typedef enum logic {RUN, BR_WAIT} ctrl_state_t;

    typedef struct packed {
        logic       v;
        logic [3:0] a;
    } pend_t;

    // R15 is the PC; it is written through the branch path, never the register file.
    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pend_sb.sv
// Three-entry in-flight write scoreboard (E, M, W) with two lookup ports.
// Entries shift one stage per advancing cycle and hold while the pipeline is frozen.
module pend_sb
    import cpu_ctrl_pkg::*;
#(
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            push,
    input  logic [RA_W-1:0] wa,
    input  logic [RA_W-1:0] ra1,
    input  logic [RA_W-1:0] ra2,
    output logic            match1,
    output logic            match2
);

    localparam logic [RA_W-1:0] PC_ADDR = RA_W'(REG_PC);

    // Valid bits per stage: bit 0 = E, bit 1 = M, bit 2 = W.
    logic [2:0]      v;
    logic [RA_W-1:0] a_e;
    logic [RA_W-1:0] a_m;
    logic [RA_W-1:0] a_w;

    // Shift valid bits E->M->W on advance; clear everything on reset.
    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (!hold) begin
            v <= {v[1], v[0], push};
        end
    end

    // Shift destination addresses alongside the valid bits.
    // NOTE: addresses carry no reset; a stale address is harmless because its valid bit gates every use.
    always_ff @(posedge clk) begin
        if (!hold) begin
            a_w <= a_m;
            a_m <= a_e;
            a_e <= wa;
        end
    end

    function automatic logic hit(input logic [RA_W-1:0] r);
        return (r != PC_ADDR) &&
               ((v[0] && (a_e == r)) || (v[1] && (a_m == r)) || (v[2] && (a_w == r)));
    endfunction

    assign match1 = hit(ra1);
    assign match2 = hit(ra2);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core without forwarding:
// stalls decode on RAW hazards, holds fetch across branches, freezes on memory busy.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  ra1D,
    input  logic [RA_W-1:0]  ra2D,
    input  logic             use1D,
    input  logic             use2D,
    input  logic [RA_W-1:0]  wa3D,
    input  logic             regWriteD,
    input  logic             pcSrcD,
    input  logic             pcSrcW,
    input  logic             memBusy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic ST_RUN     = 1'(RUN);
    localparam logic ST_BR_WAIT = 1'(BR_WAIT);

    logic state;
    logic next_state;
    logic issue;
    logic match1;
    logic match2;
    logic raw;

    pend_sb #(.RA_W(RA_W)) u_pend_sb (
        .clk    (clk),
        .rst    (rst),
        .hold   (memBusy),
        .push   (regWriteD && issue),
        .wa     (wa3D),
        .ra1    (ra1D),
        .ra2    (ra2D),
        .match1 (match1),
        .match2 (match2)
    );

    assign raw = (use1D && match1) || (use2D && match2);

    // Priority decode: reset, freeze, branch in W, branch wait, RAW, branch in D.
    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    always_comb begin
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        issue      = 1'b0;
        next_state = state;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (memBusy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (pcSrcW) begin
            // Expected end of a branch wait, or a stray redirect that also squashes D->E.
            flushD     = 1'b1;
            flushE     = (state == ST_RUN);
            next_state = ST_RUN;
        end else if (state == ST_BR_WAIT) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end else if (raw) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (pcSrcD) begin
            stallF     = 1'b1;
            flushD     = 1'b1;
            issue      = 1'b1;
            next_state = ST_BR_WAIT;
        end else begin
            issue = 1'b1;
        end
    end

    // FSM state register; holds while data memory is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (!memBusy) begin
            state <= next_state;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
        end else if (stallF && (stallCount != '1)) begin
            stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations are queued when stimulus
// is driven and popped/compared at the falling edge. A second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_hazard_ctrl;

    // Output vectors ordered {stallF, stallD, stallE, stallM, flushD, flushE}.
    localparam logic [5:0] O_RUN = 6'b000000;
    localparam logic [5:0] O_RAW = 6'b110001;
    localparam logic [5:0] O_BR  = 6'b100010;
    localparam logic [5:0] O_BRW = 6'b000010;
    localparam logic [5:0] O_FRZ = 6'b111100;
    localparam logic [5:0] O_RED = 6'b000011;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra1D, ra2D, wa3D;
    logic        use1D, use2D, regWriteD, pcSrcD, pcSrcW, memBusy;
    logic        stallF, stallD, stallE, stallM, flushD, flushE;
    logic [15:0] stallCount;
    logic        s4F, s4D, s4E, s4M, f4D, f4E;
    logic [3:0]  stallCount4;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .ra1D(ra1D), .ra2D(ra2D), .use1D(use1D), .use2D(use2D),
        .wa3D(wa3D), .regWriteD(regWriteD), .pcSrcD(pcSrcD), .pcSrcW(pcSrcW), .memBusy(memBusy),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .stallCount(stallCount)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ra1D(ra1D), .ra2D(ra2D), .use1D(use1D), .use2D(use2D),
        .wa3D(wa3D), .regWriteD(regWriteD), .pcSrcD(pcSrcD), .pcSrcW(pcSrcW), .memBusy(memBusy),
        .stallF(s4F), .stallD(s4D), .stallE(s4E), .stallM(s4M),
        .flushD(f4D), .flushE(f4E), .stallCount(stallCount4)
    );

    typedef struct {
        string       tag;
        logic [5:0]  outs;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_cnt4 = '0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive D-stage inputs, queue the expectation, compare at negedge.
    task automatic cyc(input string tag,
                       input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2,
                       input logic [3:0] w, input logic rw, input logic pd, input logic pw,
                       input logic mb, input logic [5:0] e);
        exp_t x;
        exp_t y;
        ra1D = r1; use1D = u1; ra2D = r2; use2D = u2;
        wa3D = w; regWriteD = rw; pcSrcD = pd; pcSrcW = pw; memBusy = mb;
        x.tag = tag; x.outs = e; x.cnt = m_cnt; x.cnt4 = m_cnt4;
        sbq.push_back(x);
        @(negedge clk);
        y = sbq.pop_front();
        check({y.tag, "/outs"}, {10'd0, stallF, stallD, stallE, stallM, flushD, flushE}, {10'd0, y.outs});
        check({y.tag, "/outs4"}, {10'd0, s4F, s4D, s4E, s4M, f4D, f4E}, {10'd0, y.outs});
        check({y.tag, "/cnt"}, stallCount, y.cnt);
        check({y.tag, "/cnt4"}, {12'd0, stallCount4}, {12'd0, y.cnt4});
        @(posedge clk);
        #1;
        if (rst) begin
            m_cnt  = '0;
            m_cnt4 = '0;
        end else if (e[5]) begin
            if (m_cnt != 16'hffff) m_cnt++;
            if (m_cnt4 != 4'hf) m_cnt4++;
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);
    endtask

    initial begin
        rst = 1'b1;
        ra1D = '0; ra2D = '0; wa3D = '0;
        use1D = 0; use2D = 0; regWriteD = 0; pcSrcD = 0; pcSrcW = 0; memBusy = 0;
        @(posedge clk);
        #1;

        // Reset: flushes asserted, stalls low, counter zero.
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RED);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RED);
        rst = 1'b0;
        idle("idle", 1);

        // Back-to-back RAW on R3 via source 1: three stall cycles.
        cyc("raw_prod",  0, 0, 0, 0, 3, 1, 0, 0, 0, O_RUN);
        cyc("raw_s1",    3, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("raw_s2",    3, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("raw_s3",    3, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("raw_issue", 3, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN);

        // One unrelated instruction between producer and consumer (source 2): two stalls.
        cyc("gap_prod",  0, 0, 0, 0, 5, 1, 0, 0, 0, O_RUN);
        cyc("gap_other", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        cyc("gap_s1",    0, 0, 5, 1, 0, 0, 0, 0, 0, O_RAW);
        cyc("gap_s2",    0, 0, 5, 1, 0, 0, 0, 0, 0, O_RAW);
        cyc("gap_issue", 0, 0, 5, 1, 0, 0, 0, 0, 0, O_RUN);

        // Pending write to R15 never hazards; unused source never hazards.
        cyc("r15_prod",  0, 0, 0, 0, 15, 1, 0, 0, 0, O_RUN);
        cyc("r15_read", 15, 1, 15, 1, 0, 0, 0, 0, 0, O_RUN);
        cyc("nouse_prod", 0, 0, 0, 0, 7, 1, 0, 0, 0, O_RUN);
        cyc("nouse_read", 7, 0, 7, 0, 0, 0, 0, 0, 0, O_RUN);
        idle("drain", 3);

        // Branch: issue at t, resolve in W at t+3.
        cyc("br_t0", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR);
        cyc("br_t1", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR);
        cyc("br_t2", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR);
        cyc("br_t3", 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BRW);
        cyc("br_t4", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);

        // Freeze two cycles during a RAW stall: five stall cycles total.
        cyc("frz_prod",  0, 0, 0, 0, 4, 1, 0, 0, 0, O_RUN);
        cyc("frz_s1",    4, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("frz_m1",    4, 1, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
        cyc("frz_m2",    4, 1, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
        cyc("frz_s2",    4, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("frz_s3",    4, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("frz_issue", 4, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        idle("drain", 3);

        // memBusy beats pcSrcW: freeze in BR_WAIT holds the state.
        cyc("brf_t0", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR);
        cyc("brf_t1", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR);
        cyc("brf_t2", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR);
        cyc("brf_frz", 0, 0, 0, 0, 0, 0, 0, 1, 1, O_FRZ);
        cyc("brf_t3", 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BRW);
        cyc("brf_t4", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);

        // Stray pcSrcW in RUN: redirect squashes the D write to R8; R6 still tracked.
        cyc("red_prod", 0, 0, 0, 0, 6, 1, 0, 0, 0, O_RUN);
        cyc("red_w",    0, 0, 0, 0, 8, 1, 0, 1, 0, O_RED);
        cyc("red_r8",   8, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        cyc("red_r6",   6, 1, 0, 0, 0, 0, 0, 0, 0, O_RAW);
        cyc("red_iss",  6, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        idle("drain", 3);

        // Reset mid-operation discards scoreboard entries and a pending branch.
        cyc("mrst_prod", 0, 0, 0, 0, 9, 1, 0, 0, 0, O_RUN);
        rst = 1'b1;
        cyc("mrst_sb",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_RED);
        rst = 1'b0;
        cyc("mrst_r9",   9, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        cyc("mrst_br0",  0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR);
        cyc("mrst_br1",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR);
        rst = 1'b1;
        cyc("mrst_fsm",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_RED);
        rst = 1'b0;
        cyc("mrst_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);

        // Long branch wait drives the 4-bit counter into saturation.
        cyc("sat_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR);
        for (int i = 0; i < 20; i++) cyc("sat_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR);
        cyc("sat_w",  0, 0, 0, 0, 0, 0, 0, 1, 0, O_BRW);
        cyc("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
